// File: rtl/substitution_layer_seq.sv
// Ascon substitution layer that applies the 5-bit S-box to COLS_PER_CYCLE columns per cycle.
// A state is loaded in IDLE, substituted in place over 64/COLS_PER_CYCLE cycles, then held in DONE.
module substitution_layer_seq #(
  parameter int unsigned COLS_PER_CYCLE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0][63:0] state_array_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [4:0][63:0] state_array_o
);

  localparam int unsigned N  = 64 / COLS_PER_CYCLE;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4 ||
        COLS_PER_CYCLE == 8 || COLS_PER_CYCLE == 16 || COLS_PER_CYCLE == 32 ||
        COLS_PER_CYCLE == 64)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be a power of two between 1 and 64");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             st_q;
  logic [KW-1:0]      k_q;
  logic [4:0][63:0]   state_q;
  logic [4:0][63:0]   sub_d;
  logic [5:0]         base;

  // Input bit i is word S_i, i.e. x[0] = S0[j].
  function automatic logic [4:0] sbox(input logic [4:0] x);
    logic [4:0] y;
    y[0] = (x[4] & x[1]) ^ x[3] ^ (x[2] & x[1]) ^ x[2] ^ (x[1] & x[0]) ^ x[1] ^ x[0];
    y[1] = x[4] ^ (x[3] & x[2]) ^ (x[3] & x[1]) ^ x[3] ^ (x[2] & x[1]) ^ x[2] ^ x[1] ^ x[0];
    y[2] = (x[4] & x[3]) ^ x[4] ^ x[2] ^ x[1] ^ 1'b1;
    y[3] = (x[4] & x[0]) ^ x[4] ^ (x[3] & x[0]) ^ x[3] ^ x[2] ^ x[1] ^ x[0];
    y[4] = (x[4] & x[1]) ^ x[4] ^ x[3] ^ (x[1] & x[0]) ^ x[1];
    return y;
  endfunction

  // With a single pass k_q is always zero, so wrapping the product to 6 bits is harmless.
  assign base = 6'(32'(k_q) * COLS_PER_CYCLE);

  always_comb begin
    sub_d = state_q;
    for (int unsigned c = 0; c < COLS_PER_CYCLE; c++) begin
      logic [5:0] col;
      logic [4:0] x;
      logic [4:0] y;
      col = base + 6'(c);
      for (int i = 0; i < 5; i++) begin
        x[i] = state_q[i][col];
      end
      y = sbox(x);
      for (int i = 0; i < 5; i++) begin
        sub_d[i][col] = y[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      k_q     <= '0;
      state_q <= '0;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (valid_i) begin
            state_q <= state_array_i;
            k_q     <= '0;
            ready_o <= 1'b0;
            st_q    <= StBusy;
          end
        end
        StBusy: begin
          state_q <= sub_d;
          if (k_q == KLast) begin
            valid_o <= 1'b1;
            st_q    <= StDone;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StDone: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            k_q     <= '0;
            st_q    <= StIdle;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign state_array_o = state_q;

endmodule
